// File: rtl/register_file_wb.sv
// Integer register file with write-back write port, two read ports
// and a load-pending scoreboard driving the decode stall.
module register_file_wb #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int AW        = 5,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_write_en,
    input  logic [XLEN-1:0]  data_write_from_wb,
    input  logic [AW-1:0]    immed_11_7_from_wb,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             issue_valid,
    input  logic             issue_is_load,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] pending_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] pending_next;
    logic             wr_live;
    logic             hit1;
    logic             hit2;
    logic             clr1;
    logic             clr2;

    assign wr_live = wb_write_en && (immed_11_7_from_wb != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[immed_11_7_from_wb] <= data_write_from_wb;
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_is_load && issue_rd != '0) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (wb_write_en) begin
            clr_vec[immed_11_7_from_wb] = 1'b1;
        end
        // A new load to the same rd outlives the result now retiring.
        pending_next    = (pending & ~clr_vec) | set_vec;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hit1 = BYPASS_EN && wb_write_en && (immed_11_7_from_wb == rs1_addr);
    assign hit2 = BYPASS_EN && wb_write_en && (immed_11_7_from_wb == rs2_addr);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = hit1 ? data_write_from_wb : regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = hit2 ? data_write_from_wb : regs[rs2_addr];
        end
    end

    assign clr1  = hit1;
    assign clr2  = hit2;
    assign stall = (rs1_used && pending[rs1_addr] && !clr1)
                || (rs2_used && pending[rs2_addr] && !clr2);

    assign pending_vec = pending;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb; a second instance runs with
// forwarding disabled on the same stimulus.
module tb_register_file_wb;

    logic        clk;
    logic        rst;
    logic        wb_write_en;
    logic [31:0] data_write_from_wb;
    logic [4:0]  immed_11_7_from_wb;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_valid;
    logic        issue_is_load;
    logic [4:0]  issue_rd;
    logic        flush;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic [31:0] pending_vec;
    logic [31:0] nb_rs1_data;
    logic [31:0] nb_rs2_data;
    logic        nb_stall;
    logic [31:0] nb_pending_vec;

    int checks;
    int passed;

    register_file_wb #(.BYPASS_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .wb_write_en(wb_write_en),
        .data_write_from_wb(data_write_from_wb),
        .immed_11_7_from_wb(immed_11_7_from_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .flush(flush),
        .stall(stall), .pending_vec(pending_vec)
    );

    register_file_wb #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk(clk), .rst(rst),
        .wb_write_en(wb_write_en),
        .data_write_from_wb(data_write_from_wb),
        .immed_11_7_from_wb(immed_11_7_from_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .flush(flush),
        .stall(nb_stall), .pending_vec(nb_pending_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_write_en   = 1'b0;
        issue_valid   = 1'b0;
        issue_is_load = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b0;
        idle_inputs();
        data_write_from_wb = '0;
        immed_11_7_from_wb = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        issue_rd = '0;

        // Reset then read
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        #1;
        check("rst_rs1", rs1_data, 32'h0);
        check("rst_rs2", rs2_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_pend", pending_vec, 32'h0);
        rs1_used = 1'b0;
        rs2_used = 1'b0;

        // Basic write then read
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd7;
        data_write_from_wb = 32'hDEADBEEF;
        rs1_addr = 5'd0;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd7;
        #1;
        check("wr_rd7", rs1_data, 32'hDEADBEEF);
        check("wr_rd7_nb", nb_rs1_data, 32'hDEADBEEF);

        // Write to x0 discarded
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd0;
        data_write_from_wb = 32'h12345678;
        rs2_addr = 5'd0;
        #1;
        check("x0_same", rs2_data, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("x0_after", rs2_data, 32'h0);
        check("x0_after_nb", nb_rs2_data, 32'h0);

        // Bypass
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd3;
        data_write_from_wb = 32'h11;
        @(negedge clk);
        immed_11_7_from_wb = 5'd3;
        data_write_from_wb = 32'h22;
        rs1_addr = 5'd3;
        #1;
        check("byp_on", rs1_data, 32'h22);
        check("byp_off", nb_rs1_data, 32'h11);
        @(negedge clk);
        idle_inputs();
        #1;
        check("byp_store", rs1_data, 32'h22);
        check("byp_store_nb", nb_rs1_data, 32'h22);

        // Load-use stall
        @(negedge clk);
        issue_valid = 1'b1;
        issue_is_load = 1'b1;
        issue_rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd0;
        rs2_addr = 5'd9;
        rs2_used = 1'b0;
        #1;
        check("lu_pend", pending_vec, 32'h0000_0200);
        check("lu_unused", {31'b0, stall}, 32'h0);
        rs2_used = 1'b1;
        #1;
        check("lu_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd9;
        data_write_from_wb = 32'hA5;
        #1;
        check("lu_release", {31'b0, stall}, 32'h0);
        check("lu_fwd", rs2_data, 32'hA5);
        check("lu_nb_hold", {31'b0, nb_stall}, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("lu_clr", pending_vec, 32'h0);
        check("lu_nostall", {31'b0, stall}, 32'h0);
        rs2_used = 1'b0;

        // Set beats clear on the same register
        @(negedge clk);
        issue_valid = 1'b1;
        issue_is_load = 1'b1;
        issue_rd = 5'd4;
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd4;
        data_write_from_wb = 32'h44;
        #1;
        check("sc_pre", pending_vec, 32'h0000_0010);
        @(negedge clk);
        idle_inputs();
        #1;
        check("sc_setwins", pending_vec, 32'h0000_0010);

        // Flush overrides set
        @(negedge clk);
        issue_valid = 1'b1;
        issue_is_load = 1'b1;
        issue_rd = 5'd6;
        flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush", pending_vec, 32'h0);

        // x0 never pending
        @(negedge clk);
        issue_valid = 1'b1;
        issue_is_load = 1'b1;
        issue_rd = 5'd0;
        @(negedge clk);
        idle_inputs();
        #1;
        check("x0_pend", pending_vec, 32'h0);

        // Asynchronous reset between edges
        @(negedge clk);
        wb_write_en = 1'b1;
        immed_11_7_from_wb = 5'd10;
        data_write_from_wb = 32'h55;
        issue_valid = 1'b1;
        issue_is_load = 1'b1;
        issue_rd = 5'd12;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd10;
        #1;
        check("ar_pre_rd", rs1_data, 32'h55);
        check("ar_pre_pend", pending_vec, 32'h0000_1000);
        #1;
        rst = 1'b0;
        #1;
        check("ar_rd", rs1_data, 32'h0);
        check("ar_pend", pending_vec, 32'h0);
        check("ar_rd_nb", nb_rs1_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rs1_addr = 5'd7;
        #1;
        check("ar_rd7", rs1_data, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- 32-entry integer register file: the receiving end of the write-back stage's write port.
- Consumes the write-back data and destination register index; serves two combinational read ports to decode.
- Contains a load-pending scoreboard that stalls decode while a source register awaits an in-flight load result.
- Sits between decode (read/issue side) and write-back (write side).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (x0..x31)
AW, 5, register index width (log2 NREGS)
BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = read returns stored value only

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
wb_write_en  input  1  write strobe from write-back
data_write_from_wb  input  XLEN  value to write
immed_11_7_from_wb  input  AW  destination register index (rd)
rs1_addr  input  AW  read port 1 index
rs2_addr  input  AW  read port 2 index
rs1_used  input  1  decode instruction reads rs1
rs2_used  input  1  decode instruction reads rs2
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
issue_valid  input  1  instruction leaves decode this cycle
issue_is_load  input  1  issued instruction is a load
issue_rd  input  AW  issued instruction's rd
flush  input  1  pipeline flush; clears all pending bits
stall  output  1  decode must hold (load-use hazard)
pending_vec  output  NREGS  scoreboard bits, for debug/verification

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0; all pending bits = 0. Combinational outputs follow from this: rs1_data = rs2_data = 0, stall = 0, pending_vec = 0.
- Write: on posedge clk, if wb_write_en=1 and immed_11_7_from_wb != 0, reg[rd] <= data_write_from_wb.
  - Writes to x0 are discarded.
  - Write latency 1 cycle: value visible in storage the cycle after the strobe.
- Read: combinational, 0-cycle latency.
  - rsN_data = 0 if rsN_addr == 0.
  - Else, if BYPASS_EN=1 and wb_write_en=1 and immed_11_7_from_wb == rsN_addr: rsN_data = data_write_from_wb (write-first).
  - Else rsN_data = reg[rsN_addr].
  - Both ports are independent and may address the same register.
- Scoreboard, per register i, 1 bit, updated on posedge clk:
  - set: issue_valid=1, issue_is_load=1, issue_rd == i, i != 0.
  - clear: wb_write_en=1 and immed_11_7_from_wb == i.
  - set and clear of the same i in the same cycle: set wins (newer load still in flight).
  - flush=1: all bits cleared; overrides set.
  - pending[0] is permanently 0.
- stall, combinational:
  - stall = (rs1_used & pending[rs1_addr] & ~clr1) | (rs2_used & pending[rs2_addr] & ~clr2).
  - clrN = BYPASS_EN & wb_write_en & (immed_11_7_from_wb == rsN_addr). With bypass enabled, a result arriving in the current cycle releases the stall immediately.
  - stall does not depend on issue_* inputs (no combinational loop). Decode must hold issue_valid=0 while stall=1.
- Reset mid-operation: storage and scoreboard clear immediately, without waiting for a clock edge; any in-flight write in that cycle is lost.
- No X propagation: all indices are in range (NREGS = 2^AW).

Test Plan:
- Reset then read: rst low, then high; rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0, stall=0, pending_vec=0.
- Basic write/read: write rd=7, data 0xDEADBEEF; next cycle rs1_addr=7 -> 0xDEADBEEF. Write rd=0, data 0x12345678 -> rs2_addr=0 reads 0.
- Bypass: reg[3]=0x11; same cycle wb_write_en=1, rd=3, data 0x22, rs1_addr=3 -> rs1_data=0x22 when BYPASS_EN=1, 0x11 when BYPASS_EN=0.
- Load-use stall: issue load rd=9 -> pending_vec[9]=1. Next cycle rs2_addr=9, rs2_used=1 -> stall=1. Writeback rd=9, data 0xA5 -> stall=0 that cycle with rs2_data=0xA5; pending[9]=0 next cycle. With rs2_used=0 -> stall=0 throughout.
- Simultaneous set/clear: pending[4]=1; same cycle writeback rd=4 and new load issue rd=4 -> pending[4] stays 1. Same cycle with flush=1 -> pending_vec=0.
- Async reset mid-op: reg[10]=0x55, pending[12]=1; drop rst between clock edges -> reg[10] reads 0 and pending_vec=0 immediately, before the next edge.
